// File: rtl/uart_rx_ctrl.sv
// ----------------------------------------------------------------------------
// uart_rx_ctrl
//
// Receive-side controller between the UART receiver and the CPU. Every byte
// strobed in on rx_valid is queued in a small circular FIFO. Bytes are then
// handed to the CPU one at a time: the head is loaded into cpu_data and
// cpu_int is raised until the CPU acknowledges with a rising edge on
// cpu_end_read. The CPU must drop cpu_end_read again before the next byte is
// presented. Bytes arriving while the FIFO is full (and no pop happens in that
// cycle) are dropped and latch the sticky overrun flag.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   rx_byte      in   [WIDTH-1:0] received byte
//   rx_valid     in   one-cycle strobe, rx_byte is new
//   cpu_data     out  [WIDTH-1:0] byte presented to the CPU
//   cpu_int      out  interrupt, high while cpu_data is unacknowledged
//   cpu_end_read in   CPU acknowledge level; only its rising edge counts
//   fifo_count   out  [$clog2(DEPTH):0] bytes queued (excludes cpu_data)
//   overrun      out  sticky, a byte was dropped
//   overrun_clr  in   synchronous clear of overrun
// ----------------------------------------------------------------------------
module uart_rx_ctrl #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           rx_byte,
  input  logic                       rx_valid,
  output logic [WIDTH-1:0]           cpu_data,
  output logic                       cpu_int,
  input  logic                       cpu_end_read,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overrun,
  input  logic                       overrun_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PRESENT = 2'b01,
    RELEASE = 2'b10
  } state_t;

  // Storage: no reset needed, contents are only meaningful below count_q.
  logic [WIDTH-1:0] mem [DEPTH];

  state_t           state_q, state_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] cpu_data_q, cpu_data_d;
  logic             cpu_int_q, cpu_int_d;
  logic             overrun_q, overrun_d;
  logic             ack_q, ack_d;

  logic             full;
  logic             empty;
  logic             pop;
  logic             push;
  logic             drop;
  logic             ack_rise;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  // A pop is the IDLE load of the head into cpu_data.
  assign pop      = (state_q == IDLE) && !empty;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push     = rx_valid && (!full || pop);
  assign drop     = rx_valid && full && !pop;
  assign ack_d    = cpu_end_read;
  assign ack_rise = cpu_end_read & ~ack_q;

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    cpu_data_d = cpu_data_q;
    overrun_d  = overrun_q;

    case (state_q)
      IDLE: begin
        if (pop) begin
          cpu_data_d = mem[rd_ptr_q];
          state_d    = PRESENT;
        end
      end
      PRESENT: begin
        if (ack_rise) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!cpu_end_read) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    // Set has priority over clear.
    if (overrun_clr) begin
      overrun_d = 1'b0;
    end
    if (drop) begin
      overrun_d = 1'b1;
    end
  end

  // Interrupt registered directly from the next state so it tracks PRESENT.
  assign cpu_int_d = (state_d == PRESENT);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= rx_byte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      cpu_data_q <= '0;
      cpu_int_q  <= 1'b0;
      overrun_q  <= 1'b0;
      // Start high so an acknowledge level held across reset is not an edge.
      ack_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      cpu_data_q <= cpu_data_d;
      cpu_int_q  <= cpu_int_d;
      overrun_q  <= overrun_d;
      ack_q      <= ack_d;
    end
  end

  assign cpu_data   = cpu_data_q;
  assign cpu_int    = cpu_int_q;
  assign fifo_count = count_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [7:0] cpu_data;
    logic       cpu_int;
    logic       cpu_end_read;
    logic [2:0] fifo_count;
    logic       overrun;
    logic       overrun_clr;

    int         tests  = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    uart_rx_ctrl #(.DEPTH(4), .WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .cpu_data     (cpu_data),
        .cpu_int      (cpu_int),
        .cpu_end_read (cpu_end_read),
        .fifo_count   (fifo_count),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit accept);
        rx_byte  = b;
        rx_valid = 1'b1;
        if (accept) exp_q.push_back(b);
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic check_present(input string tag);
        chk({tag, "_int"}, cpu_int, 1'b1);
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 1'b1, 1'b0);
        end else begin
            exp_b = exp_q.pop_front();
            chk({tag, "_data"}, cpu_data, exp_b);
            $display("[TB] presented %02h expected %02h", cpu_data, exp_b);
        end
    endtask

    task automatic ack_cycle(input string tag);
        cpu_end_read = 1'b1;
        tick();
        chk({tag, "_int_after_ack"}, cpu_int, 1'b0);
        cpu_end_read = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst_n        = 1'b0;
        rx_byte      = '0;
        rx_valid     = 1'b0;
        cpu_end_read = 1'b0;
        overrun_clr  = 1'b0;

        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_int", cpu_int, 1'b0);
        chk("rst_data", cpu_data, 8'h00);
        chk("rst_count", fifo_count, 3'd0);
        chk("rst_ovr", overrun, 1'b0);

        send(8'hA5, 1'b1);
        chk("single_count_n", fifo_count, 3'd1);
        chk("single_int_n", cpu_int, 1'b0);
        tick();
        check_present("single");
        chk("single_count_n1", fifo_count, 3'd0);
        ack_cycle("single");
        chk("single_idle_int", cpu_int, 1'b0);
        chk("single_idle_count", fifo_count, 3'd0);

        for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
        chk("burst_count", fifo_count, 3'd4);
        chk("burst_ovr0", overrun, 1'b0);
        check_present("burst0");
        send(8'h06, 1'b0);
        chk("burst_ovr1", overrun, 1'b1);
        chk("burst_count_full", fifo_count, 3'd4);
        for (int i = 0; i < 4; i++) begin
            ack_cycle("burst");
            check_present("burst");
            chk("burst_drain_count", fifo_count, 3'(3 - i));
        end
        ack_cycle("burst_last");
        chk("burst_done_int", cpu_int, 1'b0);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("burst_ovr_clr", overrun, 1'b0);

        for (int i = 0; i < 5; i++) send(8'(8'h10 + i), 1'b1);
        check_present("simul0");
        chk("simul_full", fifo_count, 3'd4);
        cpu_end_read = 1'b1;
        tick();
        cpu_end_read = 1'b0;
        tick();
        chk("simul_idle_int", cpu_int, 1'b0);
        send(8'h77, 1'b1);
        chk("simul_ovr", overrun, 1'b0);
        chk("simul_count", fifo_count, 3'd4);
        check_present("simul1");
        for (int i = 0; i < 4; i++) begin
            ack_cycle("simul");
            check_present("simul");
        end
        ack_cycle("simul_last");
        chk("simul_done_int", cpu_int, 1'b0);

        cpu_end_read = 1'b1;
        tick();
        send(8'hC3, 1'b1);
        tick();
        check_present("hs0");
        send(8'hD4, 1'b1);
        tick();
        tick();
        chk("hs_held_high", cpu_int, 1'b1);
        cpu_end_read = 1'b0;
        tick();
        chk("hs_low", cpu_int, 1'b1);
        cpu_end_read = 1'b1;
        tick();
        chk("hs_ack", cpu_int, 1'b0);
        tick();
        tick();
        tick();
        chk("hs_wait_low", cpu_int, 1'b0);
        chk("hs_wait_count", fifo_count, 3'd1);
        cpu_end_read = 1'b0;
        tick();
        tick();
        check_present("hs1");
        ack_cycle("hs_last");
        chk("hs_done_int", cpu_int, 1'b0);

        for (int i = 0; i < 5; i++) send(8'(8'hE0 + i), 1'b1);
        check_present("prio0");
        overrun_clr = 1'b1;
        send(8'hE5, 1'b0);
        chk("prio_set_wins", overrun, 1'b1);
        tick();
        overrun_clr = 1'b0;
        chk("prio_clear", overrun, 1'b0);

        ack_cycle("rst_pre");
        check_present("rst_pre");
        chk("rst_pre_count", fifo_count, 3'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_int", cpu_int, 1'b0);
        chk("rst_async_count", fifo_count, 3'd0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_post_count", fifo_count, 3'd0);
        chk("rst_post_data", cpu_data, 8'h00);
        tick();
        tick();
        chk("rst_post_int", cpu_int, 1'b0);
        send(8'h5A, 1'b1);
        tick();
        check_present("rst_new");

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller placed between the `uart` receiver and the CPU. It captures every byte the receiver announces with its one-cycle `read_int` pulse into a small FIFO, then presents bytes to the CPU one at a time through an interrupt/acknowledge handshake on `cpu_end_read`. Back-to-back UART frames are therefore not lost while the CPU is still servicing an earlier byte. A sticky overrun flag reports bytes dropped because the FIFO was full.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `WIDTH`, 8: data width in bits.
- `clk`  in  1: single system clock; all state updates on its rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `rx_byte`  in  WIDTH: received byte; connects to `uart_to_cpu_buf`.
- `rx_valid`  in  1: one-cycle strobe meaning `rx_byte` is new; connects to `read_int`.
- `cpu_data`  out  WIDTH: byte currently presented to the CPU.
- `cpu_int`  out  1: interrupt; high while `cpu_data` holds an unacknowledged byte.
- `cpu_end_read`  in  1: CPU acknowledge, level signal; only a rising edge counts.
- `fifo_count`  out  $clog2(DEPTH)+1: number of bytes queued, excluding the byte in `cpu_data`.
- `overrun`  out  1: sticky flag; a byte was dropped.
- `overrun_clr`  in  1: clears `overrun` synchronously.

## Operation
- FIFO:
  - Circular buffer with `rd_ptr`/`wr_ptr` of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a count register.
  - Full when count == DEPTH; empty when count == 0.
- Push: on a `rx_valid` cycle, write `rx_byte` at `wr_ptr` when not full, or when full and a pop occurs in the same cycle.
- Dropped byte: if the FIFO is full and there is no pop in that cycle, discard the byte and set `overrun`.
- Simultaneous push and pop: both happen and count is unchanged. On an empty FIFO, push and pop cannot coincide because a pop needs count > 0.
- Acknowledge edge: `ack_d` registers `cpu_end_read`; `ack_rise = cpu_end_read & ~ack_d`.
- State machine (2-bit register):
  - IDLE: `cpu_int`=0. If count > 0, load `cpu_data` from the FIFO head, pop, and go to PRESENT.
  - PRESENT: `cpu_int`=1. On `ack_rise`, go to RELEASE. `cpu_end_read` already high on entry does not acknowledge.
  - RELEASE: `cpu_int`=0. Wait for `cpu_end_read`==0, then go to IDLE.
  - Unused encoding: go to IDLE.
- `cpu_data` changes only on the load in IDLE; it holds its value through RELEASE and IDLE.
- `overrun`:
  - Set by a dropped byte.
  - Cleared by `overrun_clr`.
  - If set and clear occur in the same cycle, set wins.
- `rx_valid` is accepted in every state; the receiving path never stalls.

## Timing
- Reset (async assert, sync release):
  - state=IDLE, pointers=0, count=0, `cpu_data`=0, `cpu_int`=0, `overrun`=0, `ack_d`=1.
  - `ack_d`=1 so a `cpu_end_read` held high at reset release never counts as an edge.
- Reset mid-handshake drops the presented byte and every queued byte, and lowers `cpu_int` immediately (asynchronously).
- Latency:
  - `rx_valid` sampled at edge N with the FIFO empty and state IDLE: count=1 after N.
  - Load at N+1: `cpu_int`=1 and `cpu_data` valid after N+1, with count back to 0.
- Acknowledge: `cpu_end_read` rises before edge M, giving `ack_rise` at M; `cpu_int`=0 after M.
- Next byte: `cpu_end_read` falls before edge K, giving IDLE after K; the next byte (if queued) is presented after K+1.
- Capacity: DEPTH queued bytes plus 1 presented byte before any drop.
- All outputs are registered.

## Test plan
- Single byte: `rx_valid` with 0xA5 at edge 10 → `cpu_data`=0xA5 and `cpu_int`=1 after edge 11; raise `cpu_end_read` → `cpu_int`=0 one edge later; `fifo_count`=0 throughout after edge 11.
- Burst: 5 bytes 0x01–0x05 on consecutive cycles with no ack (DEPTH=4) → 0x01 presented, `fifo_count` reaches 4, `overrun`=0. A 6th byte 0x06 → dropped, `overrun`=1. Four ack cycles → CPU reads 0x01..0x05 in order, never 0x06.
- Simultaneous push and pop: FIFO full (4 bytes) and the CPU completes RELEASE so that the IDLE pop coincides with `rx_valid` 0x77 → 0x77 accepted, `overrun` stays 0, `fifo_count` stays 4.
- Handshake rules: `cpu_end_read` held high before the byte arrives → byte presented, no acknowledge until `cpu_end_read` goes low and then high; the next byte waits for `cpu_end_read` low.
- Overrun priority: `overrun_clr` in the same cycle as a drop → `overrun`=1; `overrun_clr` alone next cycle → `overrun`=0.
- Reset: assert `rst_n`=0 in PRESENT with 3 bytes queued → `cpu_int`=0 immediately; after release, `fifo_count`=0, `cpu_data`=0, and no interrupt until a new `rx_valid`.
